// File: rtl/pyrite_qspi_shifter_if.sv
// APB bus bundle shared by the VPD interconnect and its slaves.
// One master view and one slave view of the same wires.
interface taxi_apb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int PAUSER_W = 1,
  parameter int PWUSER_W = 1,
  parameter int PRUSER_W = 1,
  parameter int PBUSER_W = 1
);
  logic [ADDR_W-1:0]   paddr;
  logic [2:0]          pprot;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [STRB_W-1:0]   pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;
  logic [PAUSER_W-1:0] pauser;
  logic [PWUSER_W-1:0] pwuser;
  logic [PRUSER_W-1:0] pruser;
  logic [PBUSER_W-1:0] pbuser;

  modport mst (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    input  pready, prdata, pslverr, pruser, pbuser
  );

  modport slv (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    output pready, prdata, pslverr, pruser, pbuser
  );
endinterface

// File: rtl/pyrite_qspi_shifter.sv
// APB-controlled byte shifter for a single/quad SPI flash (mode 0, MSB first).
// Software owns chip select; the block only clocks one byte per DATA write.
module pyrite_qspi_shifter #(
  parameter int CLK_DIV      = 2,
  parameter int FLASH_DATA_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  taxi_apb_if.slv                 s_apb,
  output logic                    qspi_clk,
  output logic                    qspi_cs,
  input  logic [FLASH_DATA_W-1:0] qspi_dq_i,
  output logic [FLASH_DATA_W-1:0] qspi_dq_o,
  output logic [FLASH_DATA_W-1:0] qspi_dq_oe,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [7:0] CYC_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cyc_q, cyc_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  rx_q, rx_d;
  logic        cs_n_q, cs_n_d;
  logic        quad_q, quad_d;
  logic        qdir_q, qdir_d;
  logic        go_q, go_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        sck_q, sck_d;
  logic        busy_q, busy_d;
  logic [3:0]  dq_o_q, dq_o_d;
  logic [3:0]  dq_oe_q, dq_oe_d;

  logic        apb_access_s;
  logic [1:0]  reg_sel_s;
  logic        wr_reject_s;
  logic [2:0]  bit_last_s;
  logic        unused_s;

  assign apb_access_s = s_apb.psel && s_apb.penable && !pready_q;
  assign reg_sel_s    = s_apb.paddr[3:2];
  assign wr_reject_s  = s_apb.pwrite && busy_q && (reg_sel_s == 2'd0 || reg_sel_s == 2'd1);
  assign bit_last_s   = quad_q ? 3'd1 : 3'd7;
  assign unused_s     = ^{s_apb.pprot, s_apb.pauser, s_apb.pwuser, s_apb.paddr[1:0],
                          s_apb.pwdata[31:8], s_apb.pstrb[3:1]};

  // Register file, APB handshake, shift FSM and next output values.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sr_d   = rx_sr_q;
    rx_d      = rx_q;
    cs_n_d    = cs_n_q;
    quad_d    = quad_q;
    qdir_d    = qdir_q;
    go_d      = 1'b0;
    pready_d  = apb_access_s;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;

    if (apb_access_s) begin
      pslverr_d = wr_reject_s;
      if (s_apb.pwrite) begin
        prdata_d = 32'd0;
        if (s_apb.pstrb[0] && !busy_q) begin
          case (reg_sel_s)
            2'd0: begin
              cs_n_d = s_apb.pwdata[0];
              quad_d = s_apb.pwdata[1];
              qdir_d = s_apb.pwdata[2];
            end
            2'd1: begin
              tx_d = s_apb.pwdata[7:0];
              go_d = 1'b1;
            end
            default: go_d = 1'b0;
          endcase
        end else begin
          go_d = 1'b0;
        end
      end else begin
        case (reg_sel_s)
          2'd0:    prdata_d = {29'd0, qdir_q, quad_q, cs_n_q};
          2'd1:    prdata_d = {busy_q, 23'd0, rx_q};
          2'd2:    prdata_d = {31'd0, busy_q};
          default: prdata_d = 32'd0;
        endcase
      end
    end else begin
      pslverr_d = 1'b0;
    end

    // The transfer starts once the accepting pready cycle is over.
    case (state_q)
      ST_IDLE: begin
        if (go_q) begin
          state_d = ST_LOW;
          cyc_d   = 8'd0;
          bit_d   = 3'd0;
        end else begin
          cyc_d = 8'd0;
        end
      end
      ST_LOW: begin
        if (cyc_q == CYC_LAST) begin
          state_d = ST_HIGH;
          cyc_d   = 8'd0;
          rx_sr_d = quad_q ? {rx_sr_q[3:0], qspi_dq_i[3:0]} : {rx_sr_q[6:0], qspi_dq_i[1]};
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = 8'd0;
          if (bit_q == bit_last_s) begin
            state_d = ST_IDLE;
            rx_d    = (quad_q && !qdir_q) ? rx_q : rx_sr_q;
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q + 3'd1;
            tx_d    = quad_q ? {tx_q[3:0], 4'b0000} : {tx_q[6:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sck_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);

    if (state_d == ST_IDLE || (quad_d && qdir_d)) begin
      dq_o_d = 4'b1100;
    end else if (quad_d) begin
      dq_o_d = tx_d[7:4];
    end else begin
      dq_o_d = {3'b110, tx_d[7]};
    end

    if (cs_n_d) begin
      dq_oe_d = 4'b0000;
    end else if (!quad_d) begin
      dq_oe_d = 4'b1101;
    end else if (qdir_d) begin
      dq_oe_d = 4'b0000;
    end else begin
      dq_oe_d = 4'b1111;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_q      <= 8'd0;
      rx_sr_q   <= 8'd0;
      rx_q      <= 8'd0;
      cs_n_q    <= 1'b1;
      quad_q    <= 1'b0;
      qdir_q    <= 1'b0;
      go_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'd0;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      dq_o_q    <= 4'b1100;
      dq_oe_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      rx_q      <= rx_d;
      cs_n_q    <= cs_n_d;
      quad_q    <= quad_d;
      qdir_q    <= qdir_d;
      go_q      <= go_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      sck_q     <= sck_d;
      busy_q    <= busy_d;
      dq_o_q    <= dq_o_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign s_apb.pready  = pready_q;
  assign s_apb.pslverr = pslverr_q;
  assign s_apb.prdata  = prdata_q;
  assign s_apb.pruser  = '0;
  assign s_apb.pbuser  = '0;

  assign qspi_clk   = sck_q;
  assign qspi_cs    = cs_n_q;
  assign qspi_dq_o  = dq_o_q;
  assign qspi_dq_oe = dq_oe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pyrite_qspi_shifter.sv
// Bench for pyrite_qspi_shifter: register table, directed corner cases and
// random transfers against a byte-level flash/transfer model.
module tb_pyrite_qspi_shifter;

  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       qspi_clk, qspi_cs, busy;
  logic [3:0] qspi_dq_i, qspi_dq_o, qspi_dq_oe;

  taxi_apb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  pyrite_qspi_shifter #(.CLK_DIV(CLK_DIV), .FLASH_DATA_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_apb      (bus),
    .qspi_clk   (qspi_clk),
    .qspi_cs    (qspi_cs),
    .qspi_dq_i  (qspi_dq_i),
    .qspi_dq_o  (qspi_dq_o),
    .qspi_dq_oe (qspi_dq_oe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Flash model: presents bit/nibble number (rises since start) before each SCK rise.
  logic [7:0] flash_byte = 8'h00;
  logic       flash_quad = 1'b0;
  int         rise_base = 0;
  int         rise_n = 0;
  int         sck_viol = 0;
  logic       sck_prev = 1'b0;
  logic [3:0] dq_log [0:511];
  logic [3:0] oe_log [0:511];

  always_comb begin
    int  idx;
    logic b;
    idx = rise_n - rise_base;
    b = 1'b0;
    qspi_dq_i = 4'b0000;
    if (flash_quad) begin
      if (idx == 0) qspi_dq_i = flash_byte[7:4];
      else if (idx == 1) qspi_dq_i = flash_byte[3:0];
    end else if (idx >= 0 && idx < 8) begin
      b = flash_byte[7 - idx];
      qspi_dq_i = {~b, ~b, b, ~b};
    end
  end

  always @(negedge clk) begin
    sck_prev <= qspi_clk;
    if (qspi_clk && !sck_prev) begin
      dq_log[rise_n & 511] <= qspi_dq_o;
      oe_log[rise_n & 511] <= qspi_dq_oe;
      rise_n <= rise_n + 1;
    end
    if (qspi_clk && !busy) sck_viol <= sck_viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, output logic [31:0] rd, output logic err);
    bit got;
    got = 1'b0;
    rd = 32'd0;
    err = 1'b0;
    @(negedge clk);
    bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wd; bus.pstrb = strb;
    bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.pready) begin
        got = 1'b1;
        rd = bus.prdata;
        err = bus.pslverr;
        break;
      end
    end
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    if (!got) check("apb_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] model_rx = 8'h00;

  // mode: 0 single, 1 quad write, 2 quad read
  task automatic check_pattern(input logic [1:0] mode, input logic [7:0] tx, input int base);
    logic [7:0] act;
    int oe_bad, hi_bad;
    logic [3:0] exp_oe;
    int n;
    n = (mode == 2'd0) ? 8 : 2;
    exp_oe = (mode == 2'd0) ? 4'b1101 : (mode == 2'd1) ? 4'b1111 : 4'b0000;
    act = 8'h00;
    oe_bad = 0;
    hi_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (oe_log[(base + i) & 511] !== exp_oe) oe_bad++;
      if (mode == 2'd0) begin
        act = {act[6:0], dq_log[(base + i) & 511][0]};
        if (dq_log[(base + i) & 511][3:2] !== 2'b11) hi_bad++;
      end else begin
        act = {act[3:0], dq_log[(base + i) & 511]};
      end
    end
    check("oe_at_sck", oe_bad, 0);
    if (mode == 2'd0) check("wp_hold_high", hi_bad, 0);
    if (mode != 2'd2) check("tx_pattern", {24'd0, act}, {24'd0, tx});
  endtask

  task automatic run_xfer(input logic [1:0] mode, input logic [7:0] tx, input logic [7:0] fb,
                          input bit mid_read);
    logic [31:0] rd;
    logic err;
    int cnt, n;
    n = (mode == 2'd0) ? 8 : 2;
    apb_xfer(1'b1, 4'h0, (mode == 2'd0) ? 32'h0 : (mode == 2'd1) ? 32'h2 : 32'h6, 4'hF, rd, err);
    flash_byte = fb;
    flash_quad = (mode == 2'd2);
    rise_base = rise_n;
    apb_xfer(1'b1, 4'h4, {24'd0, tx}, 4'hF, rd, err);
    check("data_wr_err", {31'd0, err}, 32'd0);
    cnt = 0;
    if (mid_read) begin
      apb_xfer(1'b0, 4'h4, 32'd0, 4'h0, rd, err);
      check("data_rd_busy", rd, {1'b1, 23'd0, model_rx});
      for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
      check("busy_end", {31'd0, busy}, 32'd0);
    end else begin
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (busy) cnt++;
        else break;
      end
      check("busy_cycles", cnt, 2 * n * CLK_DIV);
    end
    @(negedge clk);
    check("sck_pulses", rise_n - rise_base, n);
    check_pattern(mode, tx, rise_base);
    if (mode != 2'd1) model_rx = fb;
    apb_xfer(1'b0, 4'h4, 32'd0, 4'h0, rd, err);
    check("data_rd_after", rd, {24'd0, model_rx});
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_cs;
    logic [3:0]  exp_oe;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [31:0] rd;
    logic err;
    int r0;
    vecs[0]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h1, 1'b0, 1'b1, 4'h0};
    vecs[1]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h0, 1'b0, 1'b1, 4'h0};
    vecs[2]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h0, 1'b0, 1'b1, 4'h0};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h0, 1'b0, 1'b1, 4'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h0,        4'hF, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[5]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[6]  = '{1'b1, 4'h0, 32'h7,        4'hE, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[8]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[9]  = '{1'b1, 4'h8, 32'hFF,       4'hF, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[10] = '{1'b1, 4'h4, 32'h55,       4'h0, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[11] = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[12] = '{1'b1, 4'h0, 32'hFF,       4'hF, 32'h0, 1'b0, 1'b1, 4'h0};
    vecs[13] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h7, 1'b0, 1'b1, 4'h0};
    vecs[14] = '{1'b1, 4'h0, 32'h2,        4'hF, 32'h0, 1'b0, 1'b0, 4'hF};
    vecs[15] = '{1'b1, 4'h0, 32'h6,        4'hF, 32'h0, 1'b0, 1'b0, 4'h0};
    vecs[16] = '{1'b1, 4'h0, 32'h0,        4'hF, 32'h0, 1'b0, 1'b0, 4'hD};
    vecs[17] = '{1'b1, 4'h0, 32'h1,        4'hF, 32'h0, 1'b0, 1'b1, 4'h0};
    vecs[18] = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h0, 1'b0, 1'b1, 4'h0};

    bus.paddr = 4'h0; bus.pprot = 3'b000; bus.psel = 1'b0; bus.penable = 1'b0;
    bus.pwrite = 1'b0; bus.pwdata = 32'd0; bus.pstrb = 4'h0;
    bus.pauser = 1'b0; bus.pwuser = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sck", {31'd0, qspi_clk}, 32'd0);
    check("rst_cs", {31'd0, qspi_cs}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pready", {31'd0, bus.pready}, 32'd0);
    check("rst_dq_o", {28'd0, qspi_dq_o}, 32'hC);
    check("rst_dq_oe", {28'd0, qspi_dq_oe}, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 19; v++) begin
      apb_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, rd, err);
      if (!vecs[v].wr) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_cs", v), {31'd0, qspi_cs}, {31'd0, vecs[v].exp_cs});
      check($sformatf("vec%0d_oe", v), {28'd0, qspi_dq_oe}, {28'd0, vecs[v].exp_oe});
      check($sformatf("vec%0d_sck", v), {31'd0, qspi_clk}, 32'd0);
    end
    check("user_zero", {30'd0, bus.pruser, bus.pbuser}, 32'd0);

    // Single read-ID style transfer, then again with a read while busy.
    run_xfer(2'd0, 8'h9F, 8'hC2, 1'b0);
    run_xfer(2'd0, 8'h9F, 8'hC2, 1'b1);
    run_xfer(2'd2, 8'h00, 8'hA5, 1'b0);
    run_xfer(2'd1, 8'h3C, 8'h99, 1'b0);

    // Writes while busy are refused and leave the shift pattern alone.
    apb_xfer(1'b1, 4'h0, 32'h0, 4'hF, rd, err);
    flash_byte = 8'h3E; flash_quad = 1'b0; rise_base = rise_n;
    apb_xfer(1'b1, 4'h4, 32'hA5, 4'hF, rd, err);
    apb_xfer(1'b1, 4'h4, 32'h00, 4'hF, rd, err);
    check("busy_data_err", {31'd0, err}, 32'd1);
    apb_xfer(1'b1, 4'h0, 32'h1, 4'hF, rd, err);
    check("busy_ctrl_err", {31'd0, err}, 32'd1);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    @(negedge clk);
    check("rej_pulses", rise_n - rise_base, 8);
    check_pattern(2'd0, 8'hA5, rise_base);
    model_rx = 8'h3E;
    apb_xfer(1'b0, 4'h0, 32'd0, 4'h0, rd, err);
    check("rej_ctrl", rd, 32'h0);
    check("rej_cs", {31'd0, qspi_cs}, 32'd0);
    apb_xfer(1'b0, 4'h4, 32'd0, 4'h0, rd, err);
    check("rej_rx", rd, {24'd0, model_rx});

    // Reset after three SCK pulses aborts the transfer.
    apb_xfer(1'b1, 4'h0, 32'h0, 4'hF, rd, err);
    flash_byte = 8'h3C; flash_quad = 1'b0; rise_base = rise_n;
    apb_xfer(1'b1, 4'h4, 32'hF0, 4'hF, rd, err);
    for (int i = 0; i < 500 && (rise_n - rise_base) < 3; i++) @(negedge clk);
    check("mid_pulses", rise_n - rise_base, 3);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sck", {31'd0, qspi_clk}, 32'd0);
    check("abort_cs", {31'd0, qspi_cs}, 32'd1);
    check("abort_oe", {28'd0, qspi_dq_oe}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dq_o", {28'd0, qspi_dq_o}, 32'hC);
    r0 = rise_n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_sck", rise_n, r0);
    model_rx = 8'h00;
    apb_xfer(1'b0, 4'h0, 32'd0, 4'h0, rd, err);
    check("abort_ctrl", rd, 32'h1);
    apb_xfer(1'b0, 4'h4, 32'd0, 4'h0, rd, err);
    check("abort_rx", rd, 32'h0);
    run_xfer(2'd0, 8'h5A, 8'h81, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_xfer(2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'b0);
    end

    check("sck_while_idle", sck_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pyrite_qspi_shifter.md
PYRITE_QSPI_SHIFTER -- requirements
Module: pyrite_qspi_shifter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter FLASH_DATA_W, default 4: flash DQ width; only 4 is supported.
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_apb, taxi_apb_if slave, DATA_W=32, ADDR_W=4: register access from the VPD APB interconnect.
REQ-006 SHALL have port qspi_clk, output, 1: SPI SCK.
REQ-007 SHALL have port qspi_cs, output, 1: chip select, active low.
REQ-008 SHALL have port qspi_dq_i, input, 4: DQ pins in.
REQ-009 SHALL have port qspi_dq_o, output, 4: DQ pins out.
REQ-010 SHALL have port qspi_dq_oe, output, 4: per-pin output enable.
REQ-011 SHALL have port busy, output, 1: transfer in progress.

Function
REQ-012 APB: pready SHALL assert for one cycle, one cycle after psel&&penable is first seen; next access accepted only after pready deasserts; pruser/pbuser SHALL be 0.
REQ-013 Register map, address bits [3:2]; pstrb[0] qualifies all writes:
- 0x0 CTRL, RW: [0] cs_n (reset 1), [1] quad (reset 0), [2] qdir, 1=read (reset 0).
- 0x4 DATA: write [7:0] = tx byte, starts a transfer; read [7:0] = last rx byte, [31] = busy.
- 0x8 STATUS, RO: [0] busy; all other bits 0.
- 0xC: reads 0, writes ignored, pslverr 0.
REQ-014 A write to CTRL or DATA while busy SHALL be ignored and SHALL complete with pslverr=1; all other accesses SHALL complete with pslverr=0.
REQ-015 FSM states IDLE, LOW, HIGH; IDLE -> LOW on accepted DATA write, in the cycle pready is asserted.
- LOW holds CLK_DIV cycles with SCK=0; then -> HIGH, SCK=1, sampling DQ.
- HIGH holds CLK_DIV cycles; then -> LOW with the next bit/nibble driven, or -> IDLE after the last one.
REQ-016 Single mode (quad=0), SPI mode 0, MSB first: 8 bits.
- tx bit driven on dq_o[0].
- rx bit sampled from qspi_dq_i[1] on entry to HIGH.
- dq_o[3:2] held at 2'b11 (WP#/HOLD# inactive).
REQ-017 Quad mode (quad=1): 2 nibbles, high nibble first.
- qdir=0: tx nibble driven on dq_o[3:0].
- qdir=1: rx nibble sampled from qspi_dq_i[3:0] on entry to HIGH; dq_o not driven.
REQ-018 dq_oe SHALL be 4'b0000 when cs_n=1; otherwise:
- single mode: 4'b1101.
- quad write: 4'b1111.
- quad read: 4'b0000.
REQ-019 busy SHALL be 1 from the cycle after the DATA-write pready through the last HIGH cycle, exactly 2*N*CLK_DIV cycles (N=8 single, N=2 quad); SCK SHALL be 0 whenever busy=0.
REQ-020 rx byte register SHALL update when busy falls; a quad write (qdir=0) SHALL leave it unchanged.
REQ-021 qspi_cs SHALL follow CTRL.cs_n directly; the block SHALL NOT toggle CS by itself.
REQ-022 Cycle counter SHALL be 8 bits wide; bit counter 3 bits wide; no wrap occurs inside a transfer.

Reset
REQ-023 On rst: state IDLE, busy=0, pready=0, qspi_clk=0, qspi_cs=1, dq_o=4'b1100, dq_oe=0, CTRL=3'b001, rx byte=0.
REQ-024 rst asserted mid-transfer SHALL abort immediately to reset values, with no further SCK edges.

Verification
REQ-025 Single transfer, CLK_DIV=2:
- stimulus: CTRL=0x0, DATA=0x9F, flash model returns 0xC2 on DQ1.
- response: 8 SCK pulses, dq0 carries 1001_1111, busy high 32 cycles, DATA read = 0x800000C2 during transfer and 0x000000C2 after.
REQ-026 Quad read:
- stimulus: CTRL=0x6, DATA=0x00, model drives 0xA then 0x5.
- response: dq_oe=0, 2 SCK pulses, rx=0xA5, busy high 8 cycles.
REQ-027 Quad write:
- stimulus: CTRL=0x2, DATA=0x3C.
- response: dq_oe=0xF, dq_o=0x3 then 0xC on successive SCK rising edges, rx byte unchanged.
REQ-028 Busy rejection: DATA write while busy -> pslverr=1, shift pattern unaltered, CTRL unchanged.
REQ-029 Reset mid-transfer:
- stimulus: rst asserted after 3 SCK pulses.
- response: next cycle qspi_clk=0, qspi_cs=1, dq_oe=0, busy=0; a new transfer after reset completes normally.
REQ-030 Idle CS control:
- stimulus: CTRL writes 0x0, then 0x1.
- response: qspi_cs follows the writes, SCK stays 0, STATUS reads 0.
